// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped IO block between the MIPS core and the board.
// Synchronises and debounces BTNL/BTNR, latches the switches when BTNR is
// pressed, holds the 32-bit display word written by the core, and scans that
// word onto the eight seven-segment digits. The core sees a status word with
// the input-ready and output-ready flags, the latched switches and the
// display word.

// io_ctrl_debounce: turns one synchronised button into a clean 1-cycle press
// pulse. The button must disagree with its settled value for CYC consecutive
// cycles before the settled value follows it. Only a settled press (0 -> 1)
// pulses; a settled release does not.
module io_ctrl_debounce #(
  parameter int CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
  output logic press
);

  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [CW-1:0] cnt;
  logic          stable;

  // Count disagreement cycles, settle after CYC of them, pulse on a settled press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync;
        cnt    <= '0;
        press  <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module io_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCAN_DIV     = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pRead,
  input  logic        pWrite,
  input  logic [1:0]  addr,
  input  logic [31:0] pWriteData,
  output logic [31:0] pReadData,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] sw,
  output logic [7:0]  an,
  output logic [6:0]  a2g
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              btn_l_s1, btn_l_s2;
  logic              btn_r_s1, btn_r_s2;
  logic [15:0]       sw_s1, sw_s2;
  logic              press_l, press_r;
  logic              wr_disp, rd_sw;
  logic [15:0]       sw_reg;
  logic [31:0]       disp_reg;
  logic              in_ready, out_ready;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;
  logic [7:0]        an_reg;
  logic [3:0]        nibble;

  assign wr_disp = pWrite && (addr == 2'd2);
  assign rd_sw   = pRead && (addr == 2'd1);

  // Two-flop synchronisers for every asynchronous board input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_l_s1 <= 1'b0;
      btn_l_s2 <= 1'b0;
      btn_r_s1 <= 1'b0;
      btn_r_s2 <= 1'b0;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      btn_l_s1 <= btnL;
      btn_l_s2 <= btn_l_s1;
      btn_r_s1 <= btnR;
      btn_r_s2 <= btn_r_s1;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
    end
  end

  io_ctrl_debounce #(.CYC(DEBOUNCE_CYC)) u_db_l (
    .clk   (clk),
    .reset (reset),
    .sync  (btn_l_s2),
    .press (press_l)
  );

  io_ctrl_debounce #(.CYC(DEBOUNCE_CYC)) u_db_r (
    .clk   (clk),
    .reset (reset),
    .sync  (btn_r_s2),
    .press (press_r)
  );

  // Input side: BTNR latches the switches and raises input-ready; a core read
  // of the switch word drops it, but a press in the same cycle takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_reg   <= '0;
      in_ready <= 1'b0;
    end else if (press_r) begin
      sw_reg   <= sw_s2;
      in_ready <= 1'b1;
    end else if (rd_sw) begin
      in_ready <= 1'b0;
    end
  end

  // Output side: a core write of the display word drops output-ready (and is
  // always accepted); BTNL raises it unless a write lands in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg  <= '0;
      out_ready <= 1'b1;
    end else if (wr_disp) begin
      disp_reg  <= pWriteData;
      out_ready <= 1'b0;
    end else if (press_l) begin
      out_ready <= 1'b1;
    end
  end

  // Digit scan: hold each digit for SCAN_DIV cycles, anode pattern kept in step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= 3'd0;
      an_reg   <= 8'hFE;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
      an_reg   <= ~(8'b1 << (digit + 3'd1));
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign an = an_reg;

  // Read mux, combinational on addr so data is valid in the same cycle
  always_comb begin
    pReadData = 32'd0;
    case (addr)
      2'd0:    pReadData = {30'd0, out_ready, in_ready};
      2'd1:    pReadData = {16'd0, sw_reg};
      2'd2:    pReadData = disp_reg;
      default: pReadData = 32'd0;
    endcase
  end

  assign nibble = disp_reg[{digit, 2'b00} +: 4];

  // Hex to active-low segment decode of the nibble for the lit digit
  always_comb begin
    a2g = 7'b1111111;
    case (nibble)
      4'h0: a2g = 7'b0000001;
      4'h1: a2g = 7'b1001111;
      4'h2: a2g = 7'b0010010;
      4'h3: a2g = 7'b0000110;
      4'h4: a2g = 7'b1001100;
      4'h5: a2g = 7'b0100100;
      4'h6: a2g = 7'b0100000;
      4'h7: a2g = 7'b0001111;
      4'h8: a2g = 7'b0000000;
      4'h9: a2g = 7'b0000100;
      4'hA: a2g = 7'b0001000;
      4'hB: a2g = 7'b1100000;
      4'hC: a2g = 7'b0110001;
      4'hD: a2g = 7'b1000010;
      4'hE: a2g = 7'b0110000;
      4'hF: a2g = 7'b0111000;
      default: a2g = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: self-checking bench for io_ctrl with short debounce/scan periods.
module tb_io_ctrl;

  localparam int DB = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pRead, pWrite;
  logic [1:0]  addr;
  logic [31:0] pWriteData, pReadData;
  logic        btnL, btnR;
  logic [15:0] sw;
  logic [7:0]  an;
  logic [6:0]  a2g;

  int tests = 0;
  int fails = 0;

  io_ctrl #(.DEBOUNCE_CYC(DB), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .pRead      (pRead),
    .pWrite     (pWrite),
    .addr       (addr),
    .pWriteData (pWriteData),
    .pReadData  (pReadData),
    .btnL       (btnL),
    .btnR       (btnR),
    .sw         (sw),
    .an         (an),
    .a2g        (a2g)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  // reference model state
  logic        mb_l1, mb_l2, mb_r1, mb_r2;
  logic [15:0] ms1, ms2, m_sw;
  logic [31:0] m_disp;
  logic        st_l, st_r, pend_l, pend_r, m_in, m_out;
  int          run_l, run_r, m_cycles;

  function automatic logic [6:0] seg(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[h];
  endfunction

  function automatic logic [7:0] an_for(input int n);
    logic [7:0] one;
    one = 8'b1 << ((n / SD) % 8);
    return ~one;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic rd, input logic [1:0] a, input logic [31:0] wd);
    pWrite     = wr;
    pRead      = rd;
    addr       = a;
    pWriteData = wd;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = pReadData;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_reset();
    mb_l1 = 0; mb_l2 = 0; mb_r1 = 0; mb_r2 = 0;
    ms1 = 0; ms2 = 0; m_sw = 0; m_disp = 0;
    st_l = 0; st_r = 0; pend_l = 0; pend_r = 0;
    m_in = 0; m_out = 1; run_l = 0; run_r = 0; m_cycles = 0;
  endtask

  // one clock edge of the specified behaviour, using the inputs currently applied
  task automatic model_step();
    if (pRead && addr == 2'd1) m_in = 0;
    if (pend_r) begin m_in = 1; m_sw = ms2; end
    if (pend_l) m_out = 1;
    if (pWrite && addr == 2'd2) begin m_out = 0; m_disp = pWriteData; end
    pend_l = 0;
    pend_r = 0;
    if (mb_l2 != st_l) begin
      run_l++;
      if (run_l == DB) begin st_l = mb_l2; run_l = 0; pend_l = mb_l2; end
    end else run_l = 0;
    if (mb_r2 != st_r) begin
      run_r++;
      if (run_r == DB) begin st_r = mb_r2; run_r = 0; pend_r = mb_r2; end
    end else run_r = 0;
    ms2 = ms1; ms1 = sw;
    mb_l2 = mb_l1; mb_l1 = btnL;
    mb_r2 = mb_r1; mb_r1 = btnR;
    m_cycles++;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_out, m_in};
      2'd1:    return {16'd0, m_sw};
      2'd2:    return m_disp;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    vec_t vecs [14];
    logic [31:0] d;
    logic        prev_in;
    int          rises;

    reset = 1'b1; btnL = 0; btnR = 0; sw = 0;
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    check_output("reset_an", {24'd0, an}, 32'h0000_00FE);
    check_output("reset_a2g", {25'd0, a2g}, {25'd0, 7'b0000001});
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // register map vectors: expected value is the read before the edge acts
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 32'd0,        32'h2};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'd0,        32'h0};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'd0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 32'd0,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'h12345678, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'd0,        32'h12345678};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'd0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 32'd0,        32'h0};
    vecs[11] = '{1'b1, 1'b1, 2'd2, 32'hCAFEF00D, 32'h12345678};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 32'd0,        32'hCAFEF00D};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 32'd0,        32'h0};
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd);
      #1;
      check_output($sformatf("vec%0d", i), pReadData, vecs[i].exp);
      @(negedge clk);
    end

    // BTNR held 10 cycles: one press, switches latched
    do_reset();
    sw = 16'h0408; btnR = 1; rises = 0; prev_in = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      peek(2'd0, d);
      if (d[0] && !prev_in) rises++;
      prev_in = d[0];
    end
    check_output("btnr_rises", rises, 1);
    check_output("btnr_status", d, 32'h3);
    peek(2'd1, d);
    check_output("btnr_sw", d, 32'h0000_0408);
    apply_stimulus(1'b0, 1'b1, 2'd1, 32'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd0, d);
    check_output("read_clears_in", d, 32'h2);
    repeat (10) @(negedge clk);
    peek(2'd0, d);
    check_output("held_no_second", d, 32'h2);
    btnR = 0;
    repeat (10) @(negedge clk);

    // short glitch and switch change alone
    btnR = 1;
    repeat (2) @(negedge clk);
    btnR = 0; rises = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      peek(2'd0, d);
      if (d[0]) rises++;
    end
    check_output("glitch_no_press", rises, 0);
    sw = 16'hFFFF;
    repeat (5) @(negedge clk);
    peek(2'd1, d);
    check_output("sw_alone", d, 32'h0000_0408);

    // press pulse and switch read in the same cycle: set wins, old value read
    sw = 16'hBEEF; btnR = 1;
    repeat (6) @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 2'd1, 32'd0);
    #1;
    check_output("rd_old_sw", pReadData, 32'h0000_0408);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd0, d);
    check_output("set_wins", d, 32'h3);
    peek(2'd1, d);
    check_output("set_wins_sw", d, 32'h0000_BEEF);
    btnR = 0;
    repeat (10) @(negedge clk);

    // scan of 0x12345678 from reset
    do_reset();
    apply_stimulus(1'b1, 1'b0, 2'd2, 32'h12345678);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd0, d);
    check_output("write_clears_out", d, 32'h0);
    for (int n = 1; n <= 18; n++) begin
      logic [31:0] disp;
      disp = 32'h12345678;
      check_output($sformatf("scan_an%0d", n), {24'd0, an}, {24'd0, an_for(n)});
      check_output($sformatf("scan_seg%0d", n), {25'd0, a2g},
                   {25'd0, seg(disp[4*((n/SD)%8) +: 4])});
      @(negedge clk);
    end

    // BTNL press raises output-ready
    btnL = 1;
    repeat (10) @(negedge clk);
    peek(2'd0, d);
    check_output("btnl_out", d, 32'h2);
    btnL = 0;
    repeat (10) @(negedge clk);

    // BTNL pulse and display write in the same cycle: write wins
    btnL = 1;
    repeat (6) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 2'd2, 32'hA5A50F0F);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd0, d);
    check_output("write_wins", d, 32'h0);
    peek(2'd2, d);
    check_output("write_wins_disp", d, 32'hA5A50F0F);
    btnL = 0;
    repeat (10) @(negedge clk);

    // reset in the middle of a debounce count with digit 5 lit
    do_reset();
    apply_stimulus(1'b1, 1'b0, 2'd2, 32'hFFFFFFFF);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'd0);
    sw = 16'h1234;
    repeat (6) @(negedge clk);
    btnR = 1;
    repeat (3) @(negedge clk);
    check_output("mid_digit5", {24'd0, an}, 32'h0000_00DF);
    @(negedge clk);
    reset = 1;
    #1;
    check_output("mid_rst_an", {24'd0, an}, 32'h0000_00FE);
    check_output("mid_rst_a2g", {25'd0, a2g}, {25'd0, 7'b0000001});
    peek(2'd0, d);
    check_output("mid_rst_st", d, 32'h2);
    peek(2'd2, d);
    check_output("mid_rst_disp", d, 32'h0);
    @(negedge clk);
    reset = 0; rises = 0; prev_in = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      peek(2'd0, d);
      if (d[0] && !prev_in) rises++;
      prev_in = d[0];
    end
    check_output("rearm_rises", rises, 1);
    peek(2'd1, d);
    check_output("rearm_sw", d, 32'h0000_1234);
    btnR = 0;
    repeat (10) @(negedge clk);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus(($urandom % 4) == 0, ($urandom % 4) == 0, 2'($urandom % 4), $urandom);
      if (($urandom % 8) == 0) sw = 16'($urandom);
      if (($urandom % 10) == 0) btnL = ~btnL;
      if (($urandom % 10) == 0) btnR = ~btnR;
      #1;
      check_output($sformatf("rnd_rd%0d", c), pReadData, model_read(addr));
      check_output($sformatf("rnd_an%0d", c), {24'd0, an}, {24'd0, an_for(m_cycles)});
      check_output($sformatf("rnd_seg%0d", c), {25'd0, a2g},
                   {25'd0, seg(m_disp[4*((m_cycles/SD)%8) +: 4])});
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
